// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied only at the output register.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DATA_W     = SEG_W + 1;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    // Raw (active-high) idle levels; the top inverts them when driving active-low pins.
    localparam logic [DATA_W-1:0]     DATA_OFF_RAW = 8'h00;
    localparam logic [NUM_DIGITS-1:0] WICH_OFF_RAW = 4'h0;

    // One display word: hex value plus per-digit decimal points.
    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [NUM_DIGITS-1:0] dp;
    } disp_word_t;

    function automatic logic [DATA_W-1:0] pol_data(logic [DATA_W-1:0] raw, bit active_low);
        return active_low ? ~raw : raw;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] pol_wich(logic [NUM_DIGITS-1:0] raw, bit active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_0;
        unique case (nibble)
            4'h0:    seg_c = SEG_0;
            4'h1:    seg_c = SEG_1;
            4'h2:    seg_c = SEG_2;
            4'h3:    seg_c = SEG_3;
            4'h4:    seg_c = SEG_4;
            4'h5:    seg_c = SEG_5;
            4'h6:    seg_c = SEG_6;
            4'h7:    seg_c = SEG_7;
            4'h8:    seg_c = SEG_8;
            4'h9:    seg_c = SEG_9;
            4'hA:    seg_c = SEG_A;
            4'hB:    seg_c = SEG_B;
            4'hC:    seg_c = SEG_C;
            4'hD:    seg_c = SEG_D;
            4'hE:    seg_c = SEG_E;
            default: seg_c = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed seven-segment scanner with frame-synchronous double buffering
// and a per-slot blanking gap against ghosting.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIV        = 50000,
    parameter int unsigned BLANK      = 2,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  lz_blank,
    input  logic                  load,
    output logic                  pending,
    output logic [DATA_W-1:0]     Dis_data,
    output logic [NUM_DIGITS-1:0] Dis_wich
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DATA_W-1:0]     DATA_OFF = pol_data(DATA_OFF_RAW, ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] WICH_OFF = pol_wich(WICH_OFF_RAW, ACTIVE_LOW);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    disp_word_t            pend_q, pend_d;
    disp_word_t            act_q, act_d;
    logic                  pending_q, pending_d;
    logic [DATA_W-1:0]     dis_data_q, dis_data_d;
    logic [NUM_DIGITS-1:0] dis_wich_q, dis_wich_d;

    logic                  last_slot_c;
    logic                  boundary_c;
    logic                  in_blank_c;
    logic                  lead_zero_c;
    logic [NIB_W-1:0]      nibble_c;
    logic [SEG_W-1:0]      seg_c;
    logic [DATA_W-1:0]     seg_raw_c;
    logic [NUM_DIGITS-1:0] sel_raw_c;

    // Prescaler and digit index; a frame ends on the last cycle of digit 3.
    always_comb begin
        last_slot_c = (cnt_q == CNT_W'(DIV - 1));
        boundary_c  = last_slot_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d       = last_slot_c ? '0 : cnt_q + CNT_W'(1);
        idx_d       = last_slot_c ? idx_q + IDX_W'(1) : idx_q;
    end

    // Double buffer: a load on the boundary cycle bypasses pend_q and commits immediately.
    always_comb begin
        pend_d    = pend_q;
        act_d     = act_q;
        pending_d = pending_q;
        if (load) begin
            pend_d.value = value_in;
            pend_d.dp    = dp_in;
            pending_d    = 1'b1;
        end
        if (boundary_c) begin
            if (load) begin
                act_d.value = value_in;
                act_d.dp    = dp_in;
            end else if (pending_q) begin
                act_d = pend_q;
            end
            pending_d = 1'b0;
        end
    end

    assign nibble_c = act_q.value[{idx_q, 2'b00} +: NIB_W];

    seg7_decode u_decode (
        .nibble (nibble_c),
        .seg_c  (seg_c)
    );

    // Digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lead_zero_c = 1'b0;
        unique case (idx_q)
            2'd3:    lead_zero_c = (act_q.value[15:12] == 4'h0);
            2'd2:    lead_zero_c = (act_q.value[15:8] == 8'h00);
            2'd1:    lead_zero_c = (act_q.value[15:4] == 12'h000);
            default: lead_zero_c = 1'b0;
        endcase
    end

    // Next display pins, built active-high then converted to pin polarity once.
    always_comb begin
        in_blank_c = (32'(cnt_q) < BLANK);
        seg_raw_c  = DATA_OFF_RAW;
        sel_raw_c  = WICH_OFF_RAW;
        if (!in_blank_c) begin
            sel_raw_c = NUM_DIGITS'(1) << idx_q;
            if (!(lz_blank && lead_zero_c)) begin
                seg_raw_c = {act_q.dp[idx_q], seg_c};
            end
        end
        dis_data_d = pol_data(seg_raw_c, ACTIVE_LOW);
        dis_wich_d = pol_wich(sel_raw_c, ACTIVE_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            act_q      <= '0;
            pending_q  <= 1'b0;
            dis_data_q <= DATA_OFF;
            dis_wich_q <= WICH_OFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pending_q  <= pending_d;
            dis_data_q <= dis_data_d;
            dis_wich_q <= dis_wich_d;
        end
    end

    assign pending  = pending_q;
    assign Dis_data = dis_data_q;
    assign Dis_wich = dis_wich_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIV=8, BLANK=2, active-low pins) against a
// time-based reference model of the display.
module tb_seg7_scan;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 4 * DIV;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic        load;
    logic        pending;
    logic [7:0]  Dis_data;
    logic [3:0]  Dis_wich;

    int n_cmp;
    int n_bad;

    seg7_scan #(.DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .dp_in    (dp_in),
        .lz_blank (lz_blank),
        .load     (load),
        .pending  (pending),
        .Dis_data (Dis_data),
        .Dis_wich (Dis_wich)
    );

    always #5 clk = ~clk;

    // Reference model: t = cycles since reset; slot and digit follow from t arithmetically.
    int unsigned t;
    logic [15:0] m_val, m_pval;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pending;
    logic [7:0]  exp_data;
    logic [3:0]  exp_wich;
    logic        exp_pend;

    function automatic logic [7:0] model_data(int unsigned tt, logic [15:0] v, logic [3:0] dp, logic lz);
        int unsigned slot = tt % DIV;
        int unsigned dig  = (tt / DIV) % 4;
        logic [15:0] upper = v >> (4 * dig);
        if (slot < BLANK) return 8'hFF;
        if (lz && dig != 0 && upper == 16'h0) return 8'hFF;
        return ~{dp[dig], GLYPH[upper[3:0]]};
    endfunction

    function automatic logic [3:0] model_wich(int unsigned tt);
        int unsigned slot = tt % DIV;
        int unsigned dig  = (tt / DIV) % 4;
        if (slot < BLANK) return 4'hF;
        return ~(4'b0001 << dig);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t         <= 0;
            m_val     <= '0;
            m_dp      <= '0;
            m_pval    <= '0;
            m_pdp     <= '0;
            m_pending <= 1'b0;
            exp_data  <= 8'hFF;
            exp_wich  <= 4'hF;
            exp_pend  <= 1'b0;
        end else begin
            exp_data <= model_data(t, m_val, m_dp, lz_blank);
            exp_wich <= model_wich(t);
            if (load) begin
                m_pval <= value_in;
                m_pdp  <= dp_in;
            end
            if ((t % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_val <= value_in;
                    m_dp  <= dp_in;
                end else if (m_pending) begin
                    m_val <= m_pval;
                    m_dp  <= m_pdp;
                end
                m_pending <= 1'b0;
                exp_pend  <= 1'b0;
            end else begin
                m_pending <= m_pending | load;
                exp_pend  <= m_pending | load;
            end
            t <= t + 1;
        end
    end

    logic [7:0] obs_data [FRAME];
    logic [3:0] obs_wich [FRAME];
    logic       obs_pend [FRAME];
    logic [7:0] ex_data  [FRAME];
    logic [3:0] ex_wich  [FRAME];
    logic       ex_pend  [FRAME];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_phase(input int unsigned phase);
        int guard = 0;
        while ((t % FRAME) != phase && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        if ((t % FRAME) != phase) begin
            n_bad++;
            $display("FAIL wait_phase timeout t=%0d want phase %0d", t, phase);
        end
    endtask

    // Captures one whole frame of pins plus the model's view of the same cycles.
    task automatic record_frame;
        for (int j = 0; j < int'(FRAME); j++) begin
            tick();
            obs_data[j] = Dis_data;
            obs_wich[j] = Dis_wich;
            obs_pend[j] = pending;
            ex_data[j]  = exp_data;
            ex_wich[j]  = exp_wich;
            ex_pend[j]  = exp_pend;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (Dis_wich !== 4'hF || Dis_data !== 8'hFF || pending !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold got wich=%h data=%h pend=%b want F FF 0", Dis_wich, Dis_data, pending);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (Dis_wich !== 4'hF || Dis_data !== 8'hFF || pending !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got wich=%h data=%h pend=%b want F FF 0", i, Dis_wich, Dis_data, pending);
            end
        end
    endtask

    task automatic test_load_basic;
        logic [7:0] want [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        lz_blank = 1'b0;
        wait_phase(3);
        value_in = 16'h1234;
        dp_in    = 4'b0000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        while ((t % FRAME) != 0) begin
            n_cmp++;
            if (pending !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_pending t=%0d got %b want 1", t, pending);
            end
            tick();
        end
        record_frame();
        for (int k = 0; k < 4; k++) begin
            int sel_cnt = 0;
            logic [3:0] selk = ~(4'b0001 << k);
            for (int j = 0; j < int'(FRAME); j++) if (obs_wich[j] === selk) sel_cnt++;
            n_cmp++;
            if (obs_data[k * DIV + DIV - 1] !== want[k]) begin
                n_bad++;
                $display("FAIL basic_glyph digit%0d got %h want %h", k, obs_data[k * DIV + DIV - 1], want[k]);
            end
            n_cmp++;
            if (sel_cnt != int'(DIV - BLANK)) begin
                n_bad++;
                $display("FAIL basic_select_cycles digit%0d got %0d want %0d", k, sel_cnt, DIV - BLANK);
            end
        end
        for (int j = 0; j < int'(FRAME); j++) begin
            n_cmp++;
            if ({obs_data[j], obs_wich[j], obs_pend[j]} !== {ex_data[j], ex_wich[j], ex_pend[j]}) begin
                n_bad++;
                $display("FAIL basic_model cyc=%0d got %h/%h/%b want %h/%h/%b", j, obs_data[j], obs_wich[j], obs_pend[j], ex_data[j], ex_wich[j], ex_pend[j]);
            end
        end
    endtask

    task automatic test_lz_blank;
        logic [7:0] want_lz [4] = '{8'hC0, 8'h88, 8'hFF, 8'hFF};
        logic [7:0] want_nl [4] = '{8'hC0, 8'h88, 8'hC0, 8'hC0};
        lz_blank = 1'b1;
        wait_phase(5);
        value_in = 16'h00A0;
        dp_in    = 4'b0000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        wait_phase(0);
        record_frame();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_data[k * DIV + DIV - 1] !== want_lz[k] || obs_wich[k * DIV + DIV - 1] !== ~(4'b0001 << k)) begin
                n_bad++;
                $display("FAIL lz_on digit%0d got %h/%h want %h/%h", k, obs_data[k * DIV + DIV - 1], obs_wich[k * DIV + DIV - 1], want_lz[k], ~(4'b0001 << k));
            end
        end
        lz_blank = 1'b0;
        record_frame();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_data[k * DIV + DIV - 1] !== want_nl[k]) begin
                n_bad++;
                $display("FAIL lz_off digit%0d got %h want %h", k, obs_data[k * DIV + DIV - 1], want_nl[k]);
            end
        end
    endtask

    task automatic test_last_wins;
        int seen_f = 0;
        lz_blank = 1'b0;
        wait_phase(2);
        value_in = 16'hFFFF;
        dp_in    = 4'b0000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        value_in = 16'h5555;
        load     = 1'b1;
        tick();
        load = 1'b0;
        while ((t % FRAME) != 0) begin
            n_cmp++;
            if (pending !== 1'b1) begin
                n_bad++;
                $display("FAIL last_wins_pending t=%0d got %b want 1", t, pending);
            end
            if (Dis_data === 8'h8E) seen_f++;
            tick();
        end
        record_frame();
        for (int j = 0; j < int'(FRAME); j++) begin
            if (obs_data[j] === 8'h8E) seen_f++;
            n_cmp++;
            if (obs_pend[j] !== 1'b0 || (obs_wich[j] !== 4'hF && obs_data[j] !== 8'h92)) begin
                n_bad++;
                $display("FAIL last_wins_frame cyc=%0d got data=%h wich=%h pend=%b want 92 and pend 0", j, obs_data[j], obs_wich[j], obs_pend[j]);
            end
        end
        n_cmp++;
        if (seen_f != 0) begin
            n_bad++;
            $display("FAIL last_wins_stale got %0d cycles of F glyph want 0", seen_f);
        end
    endtask

    task automatic test_boundary_load;
        logic [15:0] v = 16'($urandom);
        logic [3:0]  d = 4'($urandom_range(0, 15));
        lz_blank = 1'b0;
        wait_phase(FRAME - 1);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (pending !== 1'b0) begin
            n_bad++;
            $display("FAIL boundary_pending_now got %b want 0", pending);
        end
        record_frame();
        n_cmp++;
        if (obs_data[DIV - 1] !== ~{d[0], GLYPH[v[3:0]]}) begin
            n_bad++;
            $display("FAIL boundary_digit0 got %h want %h", obs_data[DIV - 1], ~{d[0], GLYPH[v[3:0]]});
        end
        for (int j = 0; j < int'(FRAME); j++) begin
            n_cmp++;
            if ({obs_data[j], obs_wich[j], obs_pend[j]} !== {ex_data[j], ex_wich[j], ex_pend[j]} || obs_pend[j] !== 1'b0) begin
                n_bad++;
                $display("FAIL boundary_model cyc=%0d got %h/%h/%b want %h/%h/0", j, obs_data[j], obs_wich[j], obs_pend[j], ex_data[j], ex_wich[j]);
            end
        end
    endtask

    task automatic test_reset_mid;
        lz_blank = 1'b0;
        wait_phase(3);
        value_in = 16'hBEEF;
        dp_in    = 4'hF;
        load     = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (pending !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pending_before got %b want 1", pending);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (Dis_wich !== 4'hF || Dis_data !== 8'hFF || pending !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_off got wich=%h data=%h pend=%b want F FF 0", Dis_wich, Dis_data, pending);
        end
        reset = 1'b0;
        record_frame();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_data[k * DIV + DIV - 1] !== 8'hC0) begin
                n_bad++;
                $display("FAIL reset_mid_zero digit%0d got %h want C0", k, obs_data[k * DIV + DIV - 1]);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            int gap = $urandom_range(0, 20);
            lz_blank = 1'($urandom_range(0, 1));
            for (int i = 0; i < gap; i++) tick();
            value_in = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = 4'($urandom_range(0, 15));
            load     = 1'b1;
            tick();
            load = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                tick();
                value_in = 16'($urandom);
                load     = 1'b1;
                tick();
                load = 1'b0;
            end
            for (int i = 0; i < 45; i++) begin
                tick();
                if (i == 20) lz_blank = ~lz_blank;
                n_cmp++;
                if ({Dis_data, Dis_wich, pending} !== {exp_data, exp_wich, exp_pend}) begin
                    n_bad++;
                    $display("FAIL random it=%0d t=%0d got %h/%h/%b want %h/%h/%b", it, t, Dis_data, Dis_wich, pending, exp_data, exp_wich, exp_pend);
                end
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        value_in = '0;
        dp_in    = '0;
        lz_blank = 1'b0;
        load     = 1'b0;
        n_cmp    = 0;
        n_bad    = 0;
        test_reset();
        test_load_basic();
        test_lz_blank();
        test_last_wins();
        test_boundary_load();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
